// File: rtl/core_pkg.sv
// core_pkg: bit positions and status encodings used on the interface between
// the control unit and the external bus interface (core_busif).
package core_pkg;

  // Output-enable vector from control
  localparam int OENB_ADDL  = 0;
  localparam int OENB_ADDH  = 1;
  localparam int OENB_DATA  = 2;
  localparam int OENB_COUNT = 3;

  // Direct pin vector from control (RD_/WR_/INTA_ are active low)
  localparam int OPIN_S0    = 0;
  localparam int OPIN_S1    = 1;
  localparam int OPIN_IOM   = 2;
  localparam int OPIN_RD    = 3;
  localparam int OPIN_WR    = 4;
  localparam int OPIN_INTA  = 5;
  localparam int OPIN_ALE   = 6;
  localparam int OPIN_COUNT = 7;

  // Synchronised input pins returned to control
  localparam int IPIN_READY = 0;
  localparam int IPIN_HOLD  = 1;
  localparam int IPIN_COUNT = 2;

  // Machine-cycle status {IO/M_, S1, S0}
  typedef enum logic [2:0] {
    CYCLE_HALT    = 3'b000,
    CYCLE_MEM_WR  = 3'b001,
    CYCLE_MEM_RD  = 3'b010,
    CYCLE_OPFETCH = 3'b011,
    CYCLE_IO_WR   = 3'b101,
    CYCLE_IO_RD   = 3'b110,
    CYCLE_INTA    = 3'b111
  } cycle_t;

  // Extract the machine-cycle status field from the control pin vector
  function automatic logic [2:0] cycle_status(input logic [OPIN_COUNT-1:0] op);
    return {op[OPIN_IOM], op[OPIN_S1], op[OPIN_S0]};
  endfunction

endpackage

// File: rtl/core_sync.sv
// core_sync: N-stage flip-flop synchroniser with asynchronous active-high
// reset. STAGES = 0 gives a plain combinational pass-through.
module core_sync #(
  parameter int STAGES = 2
) (
  input  logic clk_,
  input  logic rst_,
  input  logic d,
  output logic q
);

  generate
    if (STAGES == 0) begin : g_pass
      assign q = d;
    end else begin : g_chain
      logic [STAGES-1:0] sync_q;
      logic [STAGES-1:0] sync_d;

      for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
        if (gi == 0) begin : g_first
          assign sync_d[gi] = d;
        end else begin : g_next
          assign sync_d[gi] = sync_q[gi-1];
        end
      end

      // Shift the pin through the chain; reset clears every stage
      always_ff @(posedge clk_ or posedge rst_) begin
        if (rst_) sync_q <= '0;
        else      sync_q <= sync_d;
      end

      assign q = sync_q[STAGES-1];
    end
  endgenerate

endmodule

// File: rtl/core_busif.sv
// core_busif: external bus interface stage downstream of the control unit.
// Drives the multiplexed AD bus and A_hi, captures read data, synchronises
// READY/HOLD and generates HLDA.
// Optional macro BUSIF_ADDR_LATCH_EN adds an on-chip address-low latch
// (a_lo) and latched cycle status (cyc_stat).
module core_busif
  import core_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int ADDRSIZE    = 16,
  parameter int DATASIZE    = 8
) (
  input  logic                  clk_,
  input  logic                  rst_,
  input  logic [OENB_COUNT-1:0] oenb,
  input  logic [OPIN_COUNT-1:0] opin,
  input  logic [ADDRSIZE-1:0]   addr,
  input  logic [DATASIZE-1:0]   dout,
  inout  wire  [DATASIZE-1:0]   ad,
  output logic [7:0]            a_hi,
  output logic                  ale,
  output logic [DATASIZE-1:0]   din,
  output logic                  din_vld,
  output logic [IPIN_COUNT-1:0] ipin,
  input  logic                  ready_pin,
  input  logic                  hold_pin,
  output logic                  hlda,
`ifdef BUSIF_ADDR_LATCH_EN
  output logic [7:0]            a_lo,
  output logic [2:0]            cyc_stat,
`endif
  output logic                  bus_err
);

  logic [DATASIZE-1:0] ad_out;
  logic                ad_oe;
  logic                rd_active;
  logic                unused_opin;

  logic                ale_q, ale_d;
  logic [DATASIZE-1:0] din_q, din_d;
  logic                din_vld_q, din_vld_d;
  logic [DATASIZE-1:0] hold_byte_q, hold_byte_d;
  logic                prev_rd_q, prev_rd_d;
  logic                bus_err_q, bus_err_d;
  logic                hlda_q, hlda_d;

  // READY and HOLD each get their own synchroniser chain
  logic [IPIN_COUNT-1:0] pins_raw;
  assign pins_raw[IPIN_READY] = ready_pin;
  assign pins_raw[IPIN_HOLD]  = hold_pin;

  generate
    for (genvar gi = 0; gi < IPIN_COUNT; gi++) begin : g_sync
      core_sync #(.STAGES(SYNC_STAGES)) u_sync (
        .clk_ (clk_),
        .rst_ (rst_),
        .d    (pins_raw[gi]),
        .q    (ipin[gi])
      );
    end
  endgenerate

  // AD driver select: address low beats write data; everything floats in reset
  always_comb begin
    ad_oe  = 1'b0;
    ad_out = addr[DATASIZE-1:0];
    if (!rst_) begin
      if (oenb[OENB_ADDL]) begin
        ad_oe  = 1'b1;
        ad_out = addr[DATASIZE-1:0];
      end else if (oenb[OENB_DATA]) begin
        ad_oe  = 1'b1;
        ad_out = dout;
      end
    end
  end

  assign ad   = ad_oe ? ad_out : 'z;
  assign a_hi = (!rst_ && oenb[OENB_ADDH]) ? addr[ADDRSIZE-1 -: 8] : 'z;

  // A tristated strobe (z) must not look like an active-low assertion
  assign rd_active = ((opin[OPIN_RD] === 1'b0) || (opin[OPIN_INTA] === 1'b0))
                     && !oenb[OENB_DATA];

  // Next-state: read capture, strobe on read end, sticky conflict, HLDA
  always_comb begin
    ale_d       = opin[OPIN_ALE];
    hold_byte_d = hold_byte_q;
    din_d       = din_q;
    din_vld_d   = 1'b0;
    prev_rd_d   = rd_active;
    bus_err_d   = bus_err_q | (oenb[OENB_ADDL] & oenb[OENB_DATA]);
    hlda_d      = ipin[IPIN_HOLD] & ~oenb[OENB_ADDH];
    if (rd_active) begin
      // keep reloading through wait states so the last sample wins
      hold_byte_d = ad;
    end else if (prev_rd_q) begin
      din_d     = hold_byte_q;
      din_vld_d = 1'b1;
    end
  end

  // State registers
  always_ff @(posedge clk_ or posedge rst_) begin
    if (rst_) begin
      ale_q       <= 1'b0;
      din_q       <= '0;
      din_vld_q   <= 1'b0;
      hold_byte_q <= '0;
      prev_rd_q   <= 1'b0;
      bus_err_q   <= 1'b0;
      hlda_q      <= 1'b0;
    end else begin
      ale_q       <= ale_d;
      din_q       <= din_d;
      din_vld_q   <= din_vld_d;
      hold_byte_q <= hold_byte_d;
      prev_rd_q   <= prev_rd_d;
      bus_err_q   <= bus_err_d;
      hlda_q      <= hlda_d;
    end
  end

  assign ale     = ale_q;
  assign din     = din_q;
  assign din_vld = din_vld_q;
  assign bus_err = bus_err_q;
  assign hlda    = hlda_q;

`ifdef BUSIF_ADDR_LATCH_EN
  logic [7:0] a_lo_q, a_lo_d;
  logic [2:0] cyc_q, cyc_d;

  // Track AD and status while ALE is high; the value at ALE fall is held
  always_comb begin
    a_lo_d = a_lo_q;
    cyc_d  = cyc_q;
    if (opin[OPIN_ALE]) begin
      a_lo_d = ad[7:0];
      cyc_d  = cycle_status(opin);
    end
  end

  // Latch registers (ALE falls only on a clock edge, so the edge copy holds)
  always_ff @(posedge clk_ or posedge rst_) begin
    if (rst_) begin
      a_lo_q <= '0;
      cyc_q  <= '0;
    end else begin
      a_lo_q <= a_lo_d;
      cyc_q  <= cyc_d;
    end
  end

  assign a_lo     = (!rst_ && opin[OPIN_ALE]) ? ad[7:0] : a_lo_q;
  assign cyc_stat = (!rst_ && opin[OPIN_ALE]) ? cycle_status(opin) : cyc_q;
  assign unused_opin = opin[OPIN_WR];
`else
  assign unused_opin = ^{opin[OPIN_WR], opin[OPIN_IOM], opin[OPIN_S1], opin[OPIN_S0]};
`endif

endmodule

// File: tb/tb_core_busif.sv
// tb_core_busif: directed scenarios plus randomized traffic, checked every
// cycle against a transaction-level model of the bus interface.
module tb_core_busif;

  localparam int SYNC = 2;

  // opin patterns: {ALE, INTA_, WR_, RD_, IO/M_, S1, S0}
  localparam logic [6:0] OP_IDLE   = 7'b0111000;
  localparam logic [6:0] OP_MR_ALE = 7'b1111010;
  localparam logic [6:0] OP_MR_RD  = 7'b0110010;
  localparam logic [6:0] OP_MW_WR  = 7'b0101001;

  logic       clk_ = 1'b0;
  logic       rst_ = 1'b1;
  logic [2:0] oenb = 3'b000;
  logic [6:0] opin = OP_IDLE;
  logic [15:0] addr = 16'h0000;
  logic [7:0] dout = 8'h00;
  logic       ready_pin = 1'b1;
  logic       hold_pin  = 1'b0;
  logic [7:0] tb_ad_drv = 8'h00;

  wire  [7:0] ad;
  wire  [7:0] a_hi;
  logic       ale, din_vld, hlda, bus_err;
  logic [7:0] din;
  logic [1:0] ipin;
`ifdef BUSIF_ADDR_LATCH_EN
  logic [7:0] a_lo;
  logic [2:0] cyc_stat;
`endif

  // The bench drives AD whenever the DUT is supposed to be off the bus
  wire tb_ad_en = rst_ | ~(oenb[0] | oenb[2]);
  assign ad = tb_ad_en ? tb_ad_drv : 8'hzz;

  core_busif #(.SYNC_STAGES(SYNC), .ADDRSIZE(16), .DATASIZE(8)) dut (
    .clk_      (clk_),
    .rst_      (rst_),
    .oenb      (oenb),
    .opin      (opin),
    .addr      (addr),
    .dout      (dout),
    .ad        (ad),
    .a_hi      (a_hi),
    .ale       (ale),
    .din       (din),
    .din_vld   (din_vld),
    .ipin      (ipin),
    .ready_pin (ready_pin),
    .hold_pin  (hold_pin),
    .hlda      (hlda),
`ifdef BUSIF_ADDR_LATCH_EN
    .a_lo      (a_lo),
    .cyc_stat  (cyc_stat),
`endif
    .bus_err   (bus_err)
  );

  always #5 clk_ = ~clk_;

  int pass_cnt  = 0;
  int total_cnt = 0;
  bit cmp_en    = 1'b0;

  task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
    total_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
  endtask

  // A released output reads as z (or 0 where undriven nets resolve to 0)
  task automatic check_float(input string name, input logic [7:0] got);
    total_cnt++;
    if (got === 8'hzz || got === 8'h00) pass_cnt++;
    else $display("FAIL %s: got %h expected released bus at %0t", name, got, $time);
  endtask

  // ---------------- behavioural model ----------------
  logic [7:0] m_din;
  bit         m_vld, m_ale, m_err, m_hlda, m_in_read;
  logic [7:0] m_byte;
  logic [7:0] m_alo;
  logic [2:0] m_cyc;
  bit         q_rdy[$];
  bit         q_hold[$];

  // Byte present on AD when not in reset
  function automatic logic [7:0] bus_byte();
    if (oenb[0])      return addr[7:0];
    else if (oenb[2]) return dout;
    else              return tb_ad_drv;
  endfunction

  // Synchronised pins = pin value SYNC edges ago
  function automatic logic [1:0] exp_ipin();
    if (SYNC == 0) return {hold_pin, ready_pin};
    return {q_hold[$], q_rdy[$]};
  endfunction

  task automatic model_reset();
    m_din = 8'h00; m_vld = 0; m_ale = 0; m_err = 0; m_hlda = 0;
    m_in_read = 0; m_byte = 8'h00; m_alo = 8'h00; m_cyc = 3'b000;
    q_rdy.delete(); q_hold.delete();
    for (int i = 0; i < SYNC; i++) begin
      q_rdy.push_front(1'b0);
      q_hold.push_front(1'b0);
    end
  endtask

  task automatic model_edge();
    logic [1:0] ip;
    bit rd;
    rd = ((opin[3] == 1'b0) || (opin[5] == 1'b0)) && !oenb[2];
    ip = exp_ipin();
    m_hlda = ip[1] && !oenb[1];
    m_ale  = opin[6];
    if (oenb[0] && oenb[2]) m_err = 1;
    m_vld = 0;
    if (rd) m_byte = bus_byte();          // a read reports the last byte seen
    else if (m_in_read) begin             // strobe ended: deliver the read
      m_din = m_byte;
      m_vld = 1;
    end
    m_in_read = rd;
    if (opin[6]) begin
      m_alo = bus_byte();
      m_cyc = opin[2:0];
    end
    q_rdy.push_front(ready_pin);  void'(q_rdy.pop_back());
    q_hold.push_front(hold_pin);  void'(q_hold.pop_back());
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk_ or posedge rst_);
      if (rst_) model_reset();
      else      model_edge();
    end
  end

  // ---------------- per-cycle compare ----------------
  initial begin
    forever begin
      @(negedge clk_);
      #2;
      if (cmp_en) begin
        if (rst_ || !(oenb[0] || oenb[2])) check("ad", {8'h00, ad}, {8'h00, tb_ad_drv});
        else                               check("ad", {8'h00, ad}, {8'h00, bus_byte()});
        if (!rst_ && oenb[1]) check("a_hi", {8'h00, a_hi}, {8'h00, addr[15:8]});
        else                  check_float("a_hi_off", a_hi);
        check("ale", {15'h0, ale}, {15'h0, m_ale});
        check("din", {8'h00, din}, {8'h00, m_din});
        check("din_vld", {15'h0, din_vld}, {15'h0, m_vld});
        check("ipin", {14'h0, ipin}, rst_ ? 16'h0 : {14'h0, exp_ipin()});
        check("hlda", {15'h0, hlda}, {15'h0, m_hlda});
        check("bus_err", {15'h0, bus_err}, {15'h0, m_err});
`ifdef BUSIF_ADDR_LATCH_EN
        check("a_lo", {8'h00, a_lo}, (!rst_ && opin[6]) ? {8'h00, bus_byte()} : {8'h00, m_alo});
        check("cyc_stat", {13'h0, cyc_stat}, (!rst_ && opin[6]) ? {13'h0, opin[2:0]} : {13'h0, m_cyc});
`endif
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic set(input logic [2:0] oe, input logic [6:0] op, input logic [7:0] drv);
    oenb = oe; opin = op; tb_ad_drv = drv;
  endtask

  task automatic cyc();
    @(negedge clk_);
  endtask

  int pulses;
  int rd_left;

  initial begin
    cmp_en = 1'b1;
    cyc(); #3;
    check("rst_din", {8'h00, din}, 16'h0000);
    check("rst_din_vld", {15'h0, din_vld}, 16'h0000);
    check("rst_ale", {15'h0, ale}, 16'h0000);
    check("rst_hlda", {15'h0, hlda}, 16'h0000);
    check("rst_bus_err", {15'h0, bus_err}, 16'h0000);
    check("rst_ipin", {14'h0, ipin}, 16'h0000);
    cyc(); rst_ = 1'b0;
    repeat (3) cyc();

    // memory read
    addr = 16'h1234; set(3'b011, OP_MR_ALE, 8'h00); #3;
    check("rd_ad_addr", {8'h00, ad}, 16'h0034);
    check("rd_a_hi", {8'h00, a_hi}, 16'h0012);
    cyc(); set(3'b010, OP_MR_RD, 8'hA5); #3;
    check("rd_ale", {15'h0, ale}, 16'h0001);
    cyc(); set(3'b010, OP_MR_RD, 8'hA5);
    cyc(); set(3'b010, OP_IDLE, 8'h00); #3;
    check("rd_vld_early", {15'h0, din_vld}, 16'h0000);
    cyc(); set(3'b000, OP_IDLE, 8'h00); #3;
    check("rd_din", {8'h00, din}, 16'h00A5);
    check("rd_vld", {15'h0, din_vld}, 16'h0001);
    cyc(); #3;
    check("rd_vld_once", {15'h0, din_vld}, 16'h0000);

    // wait states
    cyc(); addr = 16'h2000; set(3'b011, OP_MR_ALE, 8'h00);
    cyc(); set(3'b010, OP_MR_RD, 8'h11); ready_pin = 1'b0; #3;
    check("ws_ipin0_a", {15'h0, ipin[0]}, 16'h0001);
    cyc(); set(3'b010, OP_MR_RD, 8'h22); #3;
    check("ws_ipin0_b", {15'h0, ipin[0]}, 16'h0001);
    cyc(); set(3'b010, OP_MR_RD, 8'h22); #3;
    check("ws_ipin0_c", {15'h0, ipin[0]}, 16'h0000);
    cyc(); set(3'b010, OP_MR_RD, 8'h22); ready_pin = 1'b1;
    cyc(); set(3'b010, OP_MR_RD, 8'h5A);
    cyc(); set(3'b010, OP_MR_RD, 8'h5A);
    cyc(); set(3'b000, OP_IDLE, 8'h00);
    pulses = 0;
    for (int i = 0; i < 4; i++) begin
      cyc(); #3;
      if (din_vld) pulses++;
    end
    check("ws_pulses", pulses[15:0], 16'h0001);
    check("ws_din", {8'h00, din}, 16'h005A);

    // write, then drive conflict
    cyc(); addr = 16'h3456; dout = 8'h3C; set(3'b110, OP_MW_WR, 8'h00); #3;
    check("wr_ad", {8'h00, ad}, 16'h003C);
    cyc(); set(3'b110, OP_MW_WR, 8'h00); #3;
    check("wr_no_vld", {15'h0, din_vld}, 16'h0000);
    cyc(); set(3'b111, OP_MW_WR, 8'h00); #3;
    check("cf_ad", {8'h00, ad}, 16'h0056);
    check("cf_err_pre", {15'h0, bus_err}, 16'h0000);
    cyc(); set(3'b000, OP_IDLE, 8'h9C); #3;
    check("cf_err", {15'h0, bus_err}, 16'h0001);
    repeat (3) cyc(); #3;
    check("cf_err_sticky", {15'h0, bus_err}, 16'h0001);

    // hold / hlda
    cyc(); addr = 16'hABCD; set(3'b000, OP_IDLE, 8'h00); hold_pin = 1'b1;
    cyc(); cyc(); #3;
    check("hold_hlda_0", {15'h0, hlda}, 16'h0000);
    cyc(); #3;
    check("hold_hlda_1", {15'h0, hlda}, 16'h0001);
    check("hold_ad_off", {8'h00, ad}, 16'h0000);
    check_float("hold_a_hi_off", a_hi);
    hold_pin = 1'b0;
    cyc(); cyc(); #3;
    check("hold_hlda_stay", {15'h0, hlda}, 16'h0001);
    cyc(); #3;
    check("hold_hlda_drop", {15'h0, hlda}, 16'h0000);

    // reset in the middle of a read
    cyc(); addr = 16'h4321; set(3'b011, OP_MR_ALE, 8'h00);
    cyc(); set(3'b010, OP_MR_RD, 8'h77);
    cyc(); set(3'b010, OP_MR_RD, 8'h77);
    cyc(); rst_ = 1'b1; #3;
    check("mr_din", {8'h00, din}, 16'h0000);
    check("mr_ipin", {14'h0, ipin}, 16'h0000);
    check("mr_err", {15'h0, bus_err}, 16'h0000);
    check("mr_ad_off", {8'h00, ad}, 16'h0077);
    check_float("mr_a_hi_off", a_hi);
    cyc(); set(3'b010, OP_IDLE, 8'h77);
    cyc(); rst_ = 1'b0;
    pulses = 0;
    for (int i = 0; i < 4; i++) begin
      cyc(); #3;
      if (din_vld) pulses++;
    end
    check("mr_no_pulse", pulses[15:0], 16'h0000);

`ifdef BUSIF_ADDR_LATCH_EN
    // address latch
    cyc(); addr = 16'h00C7; set(3'b011, OP_MR_ALE, 8'h00); #3;
    check("lat_open", {8'h00, a_lo}, 16'h00C7);
    check("lat_stat", {13'h0, cyc_stat}, 16'h0002);
    cyc(); dout = 8'hFF; set(3'b100, OP_MW_WR, 8'h00); #3;
    check("lat_data_on_bus", {8'h00, ad}, 16'h00FF);
    check("lat_hold", {8'h00, a_lo}, 16'h00C7);
    cyc(); set(3'b000, OP_IDLE, 8'h00);
`endif

    // randomized traffic
    rd_left = 0;
    for (int n = 0; n < 3000; n++) begin
      cyc();
      rst_      = ($urandom % 300) == 0;
      addr      = 16'($urandom);
      dout      = 8'($urandom);
      tb_ad_drv = 8'($urandom);
      if (($urandom % 8) == 0) ready_pin = ~ready_pin;
      if (($urandom % 16) == 0) hold_pin = ~hold_pin;
      case ($urandom % 64)
        0:                 oenb[0] = 1'b1;
        default: oenb[0] = 1'b0;
      endcase
      case ($urandom % 8)
        0, 1, 2: begin oenb[0] = 1'b1; oenb[2] = oenb[0] & (($urandom % 32) == 0); end
        3, 4:    begin oenb[0] = 1'b0; oenb[2] = 1'b1; end
        default: begin oenb[0] = 1'b0; oenb[2] = 1'b0; end
      endcase
      oenb[1] = 1'($urandom);
      opin[2:0] = 3'($urandom);
      opin[6]   = ($urandom % 4) == 0;
      opin[4]   = ($urandom % 4) != 0;
      opin[3]   = 1'b1;
      opin[5]   = 1'b1;
      if (rd_left > 0) begin
        if (($urandom % 4) == 0) opin[5] = 1'b0;
        else                     opin[3] = 1'b0;
        rd_left--;
      end else if (($urandom % 6) == 0) begin
        rd_left = $urandom_range(1, 4);
      end
    end
    cyc(); rst_ = 1'b0;
    cyc();
    cmp_en = 1'b0;

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/core_busif.md
Name: core_busif

Overview:
- External bus interface stage directly downstream of the core control unit.
- Consumes the control unit's output-enable vector (oenb) and direct pin vector (opin).
- Drives the multiplexed AD[7:0] bus and the A[15:8] bus.
- Captures read data and returns it to the datapath with a one-cycle valid strobe.
- Synchronises the external READY/HOLD pins into the control unit's ipin vector and generates HLDA.

Parameters:
- SYNC_STAGES, 2, flip-flop stages on READY and HOLD; legal values 0, 1, 2; 0 = combinational pass-through.
- ADDRSIZE, 16, address width; fixed 8 high + 8 low.
- DATASIZE, 8, data width.

Ports:
- clk_  input  1  clock; all flops on posedge
- rst_  input  1  reset; asynchronous, active-high
- oenb  input  3  from control: [0] ADDL, [1] ADDH, [2] DATA output enables
- opin  input  7  from control: [0] S0, [1] S1, [2] IO/M_, [3] RD_, [4] WR_, [5] INTA_, [6] ALE
- addr  input  16  bus address from register file (PC/HL/etc. selected upstream)
- dout  input  8  write data from datapath
- ad  inout  8  multiplexed address-low/data bus
- a_hi  output  8  address high; high-Z when oenb[1]=0
- ale  output  1  registered copy of opin[6]
- din  output  8  captured read byte
- din_vld  output  1  one-cycle pulse; din valid
- ipin  output  2  to control: [0] READY sync, [1] HOLD sync
- ready_pin  input  1  external READY
- hold_pin  input  1  external HOLD
- hlda  output  1  hold acknowledge
- bus_err  output  1  sticky: AD drive conflict detected

Behaviour:
- Reset (async, rst_=1) values:
  - din=0x00, din_vld=0, ale=0, hlda=0, bus_err=0.
  - Sync flops cleared, so ipin=2'b00 until the pins propagate.
  - ad and a_hi are high-Z.
- AD drive priority:
  - oenb[0]=1: ad=addr[7:0].
  - Else oenb[2]=1: ad=dout.
  - Else high-Z.
  - oenb[0] and oenb[2] both 1 on a clock edge: addr wins and bus_err sets; bus_err clears only on reset.
- a_hi = addr[15:8] when oenb[1]=1, else high-Z.
- ale is the registered opin[6], i.e. one cycle behind control.
- Read capture:
  - On each posedge with rd_active=(~opin[3] | ~opin[5]) & ~oenb[2], load an internal hold register from ad.
  - Track prev_rd = rd_active.
  - On the edge where prev_rd=1 and rd_active=0: din <= hold register, din_vld=1 for exactly one cycle.
  - Read latency: din_vld asserts 1 cycle after RD_/INTA_ rise; din holds its value until the next capture.
- opin[3:5] high-Z (control tristated) is treated as inactive; the capture logic uses case-equality on 1'b0.
- Wait states: rd_active remains 1 through T2/TW/T3. The hold register keeps reloading, so the last T3 sample wins.
- Synchroniser: ipin[0]=READY and ipin[1]=HOLD, each delayed by SYNC_STAGES cycles.
- HLDA:
  - hlda <= ipin[1] & ~oenb[1], registered.
  - Rises one cycle after control releases A_hi while HOLD is synchronised high.
  - Falls the cycle after the synchronised HOLD drops.
- Simultaneous RD_ rise and HOLD: din_vld still issues; hlda is unaffected.
- Reset mid-read: no din_vld pulse is generated for the aborted cycle.

Optional Feature:
- Macro BUSIF_ADDR_LATCH_EN.
- Defined:
  - Adds output a_lo[7:0], a 74x373-style transparent latch of ad while opin[6]=1, holding on the ALE fall.
  - Adds output cyc_stat[2:0] = {IO/M_,S1,S0}, latched on ALE high.
  - Both reset to 0.
- Undefined: neither port exists; external demux is required.

Decomposition:
- Shared package core_pkg:
  - OENB_*, OPIN_*, IPIN_* bit-index constants and their COUNT widths.
  - CYCLE_* status/control encodings.
  - Shared with the control unit.
- One sub-module, core_sync: a parameterised N-stage synchroniser with async reset, instantiated for READY and HOLD.

Test Plan:
- Memory read: addr=0x1234, oenb ADDL/ADDH=1, ALE pulse, then RD_ low for 2 cycles with a bench drive of ad=0xA5.
  - Required: ad=0x34 and a_hi=0x12 while ADDL is on.
  - Required: din=0xA5 and din_vld=1 for 1 cycle, 1 cycle after RD_ rises.
- Wait states: READY low for 3 cycles, bench ad changes 0x11→0x22→0x5A before RD_ rises.
  - Required: ipin[0] lags ready_pin by 2 cycles.
  - Required: din=0x5A, a single din_vld pulse.
- Write: dout=0x3C, oenb DATA=1, WR_ low.
  - Required: ad=0x3C, no din_vld.
  - Then force ADDL=DATA=1: required ad=addr[7:0] and bus_err=1, sticky until rst_.
- Hold: hold_pin=1 while oenb=000.
  - Required: hlda=1 at cycle SYNC_STAGES+1, ad and a_hi high-Z.
  - Drop hold_pin: hlda=0 after SYNC_STAGES+1 cycles.
- Reset mid-read: assert rst_ while RD_ is low.
  - Required: din=0x00, din_vld stays 0 after RD_ rises, ipin=00, bus high-Z.
- BUSIF_ADDR_LATCH_EN: ALE high with addr=0x00C7, then ad switches to data 0xFF.
  - Required: a_lo stays 0xC7.
